// File: rtl/axiuart_pkg.sv
// Shared types and helpers for the UART-AXI4 bridge serial front ends.
package axiuart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} uart_rx_state_t;

  // Clock cycles per oversample tick, rounded to nearest.
  function automatic int uart_tick_div(int clk_hz, int baud, int os);
    return (clk_hz + (baud * os) / 2) / (baud * os);
  endfunction

endpackage

// File: rtl/uart_rx_frontend_if.sv
// Byte delivery and status signals between the RX front end and the bridge.
interface uart_rx_frontend_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       break_det;
  logic       rx_busy;

  modport master (
    output rx_data, rx_valid, frame_err, overrun, break_det, rx_busy,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, frame_err, overrun, break_det, rx_busy,
    output rx_ready
  );
endinterface

// File: rtl/uart_baud_tick_gen.sv
// Free-running divider producing a one-clock tick every DIV clocks.
module uart_baud_tick_gen #(
  parameter int unsigned DIV = 68
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Next count: wrap to zero after DIV-1.
  always_comb begin
    cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + CntW'(1);
  end

  // Divider state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == CntLast);
endmodule

// File: rtl/uart_rx_frontend.sv
// Oversampled 8N1 UART receiver: synchroniser, start validation, majority
// sampling, byte handshake and framing/overrun/break status.
module uart_rx_frontend
  import axiuart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 125_000_000,
  parameter int unsigned BAUD_RATE   = 115200,
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   uart_rx,
  uart_rx_frontend_if.master     rx_if
);
  localparam int unsigned DIV = uart_tick_div(int'(CLK_FREQ_HZ), int'(BAUD_RATE),
                                              int'(OVERSAMPLE));
  localparam int unsigned TW  = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TMid0 = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TMid1 = TW'(OVERSAMPLE / 2);
  localparam logic [TW-1:0] TMid2 = TW'(OVERSAMPLE / 2 + 1);
  localparam logic [TW-1:0] TLast = TW'(OVERSAMPLE - 1);

  logic                   tick;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  uart_rx_state_t         state_q, state_d;
  logic [TW-1:0]          tcnt_q, tcnt_d, tcnt_nxt;
  logic [2:0]             bitcnt_q, bitcnt_d;
  logic [7:0]             shift_q, shift_d;
  logic [1:0]             samp_q, samp_d;
  logic [7:0]             rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overrun_q, overrun_d;
  logic                   maj, mid_tick, last_tick;

  uart_baud_tick_gen #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  assign rx_s      = sync_q[SYNC_STAGES-1];
  // Third sample is the live synced value; decision made on that tick.
  assign maj       = (samp_q[1] & samp_q[0]) | (samp_q[1] & rx_s) | (samp_q[0] & rx_s);
  assign mid_tick  = tick && (tcnt_q == TMid2);
  assign last_tick = tick && (tcnt_q == TLast);
  assign tcnt_nxt  = (tcnt_q == TLast) ? '0 : tcnt_q + TW'(1);

  // Next-state, sampling, shift register and output handshake.
  always_comb begin
    state_d     = state_q;
    tcnt_d      = tcnt_q;
    bitcnt_d    = bitcnt_q;
    shift_d     = shift_q;
    samp_d      = samp_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    if (rx_valid_q && rx_if.rx_ready) rx_valid_d = 1'b0;

    if (tick && (tcnt_q == TMid0 || tcnt_q == TMid1)) samp_d = {samp_q[0], rx_s};

    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d  = START;
          tcnt_d   = '0;
          bitcnt_d = '0;
        end
      end
      START: begin
        if (tick) tcnt_d = tcnt_nxt;
        if (mid_tick && maj) state_d = IDLE;
        else if (last_tick)  state_d = DATA;
      end
      DATA: begin
        if (tick) tcnt_d = tcnt_nxt;
        if (mid_tick) shift_d = {maj, shift_q[7:1]};
        if (last_tick) begin
          if (bitcnt_q == 3'd7) state_d = STOP;
          else                  bitcnt_d = bitcnt_q + 3'd1;
        end
      end
      STOP: begin
        if (tick) tcnt_d = tcnt_nxt;
        if (mid_tick) begin
          if (maj) begin
            state_d = IDLE;
            // A byte still waiting unaccepted wins; the new one is dropped.
            if (!rx_valid_q || rx_if.rx_ready) begin
              rx_data_d  = shift_q;
              rx_valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            frame_err_d = 1'b1;
            tcnt_d      = '0;
            state_d     = (shift_q == 8'h00) ? BREAK : IDLE;
          end
        end
      end
      BREAK: begin
        // tcnt counts consecutive high ticks here.
        if (tick) begin
          if (!rx_s) begin
            tcnt_d = '0;
          end else if (tcnt_q == TLast) begin
            tcnt_d  = '0;
            state_d = IDLE;
          end else begin
            tcnt_d = tcnt_nxt;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; synchroniser resets to idle-high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= '1;
      state_q     <= IDLE;
      tcnt_q      <= '0;
      bitcnt_q    <= '0;
      shift_q     <= '0;
      samp_q      <= '0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], uart_rx};
      state_q     <= state_d;
      tcnt_q      <= tcnt_d;
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      samp_q      <= samp_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_if.rx_data   = rx_data_q;
  assign rx_if.rx_valid  = rx_valid_q;
  assign rx_if.frame_err = frame_err_q;
  assign rx_if.overrun   = overrun_q;
  assign rx_if.break_det = (state_q == BREAK);
  assign rx_if.rx_busy   = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx_frontend.sv
// Self-checking bench for uart_rx_frontend. A scaled system clock gives a
// 128-clock bit so the whole run stays short; timing ratios match defaults.
module tb_uart_rx_frontend;
  localparam int CLK_HZ = 14_745_600;
  localparam int BAUD   = 115200;
  localparam int OS     = 16;
  localparam int DIV    = (CLK_HZ + BAUD * OS / 2) / (BAUD * OS);
  localparam int B      = DIV * OS;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic uart_rx = 1'b1;

  uart_rx_frontend_if rx_if ();

  uart_rx_frontend #(
    .CLK_FREQ_HZ (CLK_HZ),
    .BAUD_RATE   (BAUD),
    .OVERSAMPLE  (OS),
    .SYNC_STAGES (2)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .uart_rx (uart_rx),
    .rx_if   (rx_if)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int got_cnt = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;
  bit brk_seen = 1'b0;
  logic [7:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int bclk);
    uart_rx = 1'b0;
    wait_clk(bclk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      wait_clk(bclk);
    end
    uart_rx = stop;
    wait_clk(bclk);
    uart_rx = 1'b1;
  endtask

  // Scoreboard: every accepted byte must be the oldest expected one.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_if.frame_err) ferr_cnt++;
      if (rx_if.overrun) ovr_cnt++;
      if (rx_if.break_det) brk_seen = 1'b1;
      if (rx_if.rx_valid && rx_if.rx_ready) begin
        got_cnt++;
        if (exp_q.size() == 0) check_eq("spurious_byte", 32'(rx_if.rx_data), 32'hFFFF_FFFF);
        else check_eq("rx_data", 32'(rx_if.rx_data), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    int g0, f0, o0, bclk;
    logic [7:0] b;
    rx_if.rx_ready = 1'b1;
    wait_clk(4);
    check_eq("rst_valid", 32'(rx_if.rx_valid), 0);
    check_eq("rst_data", 32'(rx_if.rx_data), 0);
    check_eq("rst_ferr", 32'(rx_if.frame_err), 0);
    check_eq("rst_ovr", 32'(rx_if.overrun), 0);
    check_eq("rst_brk", 32'(rx_if.break_det), 0);
    check_eq("rst_busy", 32'(rx_if.rx_busy), 0);
    rst_n = 1'b1;
    wait_clk(3 * B);

    // 1: clean frame, nominal and +/-3% skew
    for (int k = 0; k < 3; k++) begin
      bclk = (k == 0) ? B : (k == 1) ? (B * 103) / 100 : (B * 97) / 100;
      g0 = got_cnt; f0 = ferr_cnt;
      exp_q.push_back(8'hA5);
      send_frame(8'hA5, 1'b1, bclk);
      check_eq("s1_busy_after_stop", 32'(rx_if.rx_busy), 0);
      wait_clk(B);
      check_eq("s1_bytes", got_cnt - g0, 1);
      check_eq("s1_ferr", ferr_cnt - f0, 0);
    end

    // 2: short low glitch rejected
    g0 = got_cnt; f0 = ferr_cnt;
    uart_rx = 1'b0;
    wait_clk((B * 300) / 1088);
    uart_rx = 1'b1;
    wait_clk(B * 3 / 4 - (B * 300) / 1088);
    check_eq("s2_busy", 32'(rx_if.rx_busy), 0);
    wait_clk(B);
    check_eq("s2_bytes", got_cnt - g0, 0);
    check_eq("s2_ferr", ferr_cnt - f0, 0);

    // 3: bad stop, then good frame
    g0 = got_cnt; f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0, B);
    wait_clk(2 * B);
    check_eq("s3_ferr", ferr_cnt - f0, 1);
    check_eq("s3_no_byte", got_cnt - g0, 0);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, B);
    wait_clk(B);
    check_eq("s3_next_byte", got_cnt - g0, 1);

    // 4: break
    g0 = got_cnt; f0 = ferr_cnt; brk_seen = 1'b0;
    uart_rx = 1'b0;
    wait_clk(12 * B);
    check_eq("s4_brk_low", 32'(rx_if.break_det), 1);
    uart_rx = 1'b1;
    wait_clk(64);
    check_eq("s4_brk_held", 32'(rx_if.break_det), 1);
    wait_clk(136);
    check_eq("s4_brk_clear", 32'(rx_if.break_det), 0);
    check_eq("s4_brk_seen", 32'(brk_seen), 1);
    check_eq("s4_ferr", ferr_cnt - f0, 1);
    check_eq("s4_no_byte", got_cnt - g0, 0);
    wait_clk(B);

    // 5: overrun with consumer stalled
    o0 = ovr_cnt; g0 = got_cnt;
    rx_if.rx_ready = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, B);
    wait_clk(B);
    check_eq("s5_valid", 32'(rx_if.rx_valid), 1);
    check_eq("s5_data1", 32'(rx_if.rx_data), 32'h11);
    send_frame(8'h22, 1'b1, B);
    wait_clk(B);
    check_eq("s5_ovr", ovr_cnt - o0, 1);
    check_eq("s5_data_held", 32'(rx_if.rx_data), 32'h11);
    rx_if.rx_ready = 1'b1;
    wait_clk(4);
    check_eq("s5_drained", got_cnt - g0, 1);
    check_eq("s5_valid_clr", 32'(rx_if.rx_valid), 0);

    // 6: reset mid-frame
    g0 = got_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
    uart_rx = 1'b0;
    wait_clk(B);
    uart_rx = 1'b1;
    wait_clk(4 * B + B / 2);
    rst_n = 1'b0;
    wait_clk(5);
    check_eq("s6_rst_busy", 32'(rx_if.rx_busy), 0);
    rst_n = 1'b1;
    wait_clk(2 * B);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, B);
    wait_clk(B);
    check_eq("s6_bytes", got_cnt - g0, 1);
    check_eq("s6_flags", (ferr_cnt - f0) + (ovr_cnt - o0), 0);

    // Random frames with random skew and gaps
    g0 = got_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
    for (int k = 0; k < 24; k++) begin
      b = 8'($urandom);
      bclk = B - 3 + int'($urandom_range(0, 6));
      exp_q.push_back(b);
      send_frame(b, 1'b1, bclk);
      wait_clk(int'($urandom_range(B / 2, 2 * B)));
    end
    wait_clk(B);
    check_eq("rand_bytes", got_cnt - g0, 24);
    check_eq("rand_flags", (ferr_cnt - f0) + (ovr_cnt - o0), 0);
    check_eq("queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
